spi_bus_arbiter: RTL

Round-robin controller that shares one SPI bus between two requesters, each owning its own chip select. It accepts word-transfer requests, grants one requester at a time and generates sclk/MOSI itself. It samples MISO and returns the received word with a done pulse. It sits between the command/data sources and the SPI slaves.

---
 rtl/spi_bus_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spi_bus_arbiter.sv
// Two-requester round-robin SPI master: grants one requester at a time, shifts a
// word MSB first on its own chip select and returns the received word with a done pulse.
module spi_bus_arbiter #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int GAP     = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic [DATA_W-1:0] i_tx0,
  input  logic [DATA_W-1:0] i_tx1,
  input  logic              i_miso,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_done0,
  output logic              o_done1,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_busy,
  output logic              o_cs0_n,
  output logic              o_cs1_n,
  output logic              o_sclk,
  output logic              o_mosi
);

  localparam int CNT_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW      = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_DONE, S_GAP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_divCnt;
  logic [BW-1:0]     r_bitCnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_rxShift;
  logic [DATA_W-1:0] r_rxData;
  logic              r_owner;
  logic              r_lastServed;
  logic              r_gnt0, r_gnt1, r_done0, r_done1;
  logic              r_busy, r_cs0n, r_cs1n, r_sclk, r_mosi;

  logic w_gnt0, w_gnt1, w_done0, w_done1;
  logic w_phaseEnd, w_gapEnd, w_active;
  logic w_cs0n, w_cs1n, w_sclk, w_mosi, w_busy;
  logic w_enterHigh, w_enterLow;

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Output values are decoded from the current state and then registered, so every
  // pin trails the state register by one cycle.
  always_comb begin
    w_next     = r_state;
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    w_done0    = 1'b0;
    w_done1    = 1'b0;
    w_phaseEnd = (int'(r_divCnt) == CLK_DIV - 1);
    w_gapEnd   = (int'(r_divCnt) == GAP - 1);
    case (r_state)
      S_IDLE: begin
        if (i_req0 && (!i_req1 || r_lastServed)) begin
          w_gnt0 = 1'b1;
          w_next = S_SETUP;
        end else if (i_req1) begin
          w_gnt1 = 1'b1;
          w_next = S_SETUP;
        end
      end
      S_SETUP: if (w_phaseEnd) w_next = S_HIGH;
      S_HIGH:  if (w_phaseEnd) w_next = S_LOW;
      S_LOW: begin
        if (w_phaseEnd) w_next = (r_bitCnt == '0) ? S_DONE : S_HIGH;
      end
      S_DONE: begin
        w_done0 = !r_owner;
        w_done1 = r_owner;
        w_next  = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP:   if (w_gapEnd) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_active    = (r_state == S_SETUP) || (r_state == S_HIGH) || (r_state == S_LOW);
    w_cs0n      = !(w_active && !r_owner);
    w_cs1n      = !(w_active && r_owner);
    w_sclk      = (r_state == S_HIGH);
    w_mosi      = w_active ? r_shift[DATA_W-1] : r_mosi;
    w_busy      = (r_state != S_IDLE);
    w_enterHigh = (r_state != S_HIGH) && (w_next == S_HIGH);
    w_enterLow  = (r_state == S_HIGH) && (w_next == S_LOW);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_divCnt     <= '0;
      r_bitCnt     <= '0;
      r_shift      <= '0;
      r_rxShift    <= '0;
      r_rxData     <= '0;
      r_owner      <= 1'b0;
      r_lastServed <= 1'b1;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_busy       <= 1'b0;
      r_cs0n       <= 1'b1;
      r_cs1n       <= 1'b1;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
    end else begin
      r_gnt0  <= w_gnt0;
      r_gnt1  <= w_gnt1;
      r_done0 <= w_done0;
      r_done1 <= w_done1;
      r_busy  <= w_busy;
      r_cs0n  <= w_cs0n;
      r_cs1n  <= w_cs1n;
      r_sclk  <= w_sclk;
      r_mosi  <= w_mosi;
      if ((w_next != r_state) || (r_state == S_IDLE) || (r_state == S_DONE))
        r_divCnt <= '0;
      else
        r_divCnt <= r_divCnt + CW'(1);
      if (w_gnt0 || w_gnt1) begin
        r_shift      <= w_gnt0 ? i_tx0 : i_tx1;
        r_owner      <= w_gnt1;
        r_lastServed <= w_gnt1;
        r_bitCnt     <= BW'(DATA_W);
      end
      if (w_enterHigh) r_rxShift <= {r_rxShift[DATA_W-2:0], i_miso};
      // The final LOW phase does not shift, so mosi keeps showing bit 0.
      if (w_enterLow) begin
        r_bitCnt <= r_bitCnt - BW'(1);
        if (r_bitCnt != BW'(1)) r_shift <= {r_shift[DATA_W-2:0], 1'b0};
      end
      if (r_state == S_DONE) r_rxData <= r_rxShift;
    end
  end

  assign o_gnt0    = r_gnt0;
  assign o_gnt1    = r_gnt1;
  assign o_done0   = r_done0;
  assign o_done1   = r_done1;
  assign o_rx_data = r_rxData;
  assign o_busy    = r_busy;
  assign o_cs0_n   = r_cs0n;
  assign o_cs1_n   = r_cs1n;
  assign o_sclk    = r_sclk;
  assign o_mosi    = r_mosi;

endmodule
